adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 14, operand width; sums are WIDTH+1 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-004 req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; handshake fires when valid and ready are both high at a rising edge.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands, sampled only on handshake.
REQ-007 resp_valid  output  2  per-requester result valid.
REQ-008 resp_ready  input  2  per-requester result accept.
REQ-009 resp_sum  output  WIDTH+1  result, shared; meaningful only while a resp_valid bit is high.
REQ-010 add_a, add_b  output  WIDTH  operands driven to the shared combinational adder.
REQ-011 add_sum  input  WIDTH+1  sum returned by the shared adder.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ops_served  output  16  count of completed response handshakes.

Function
REQ-014 FSM states IDLE, EVAL, RESP; exactly one request in flight at a time.
REQ-015 IDLE: req_ready is one-hot or zero; it selects the single valid requester, or the priority-pointer requester if both are valid; zero if none valid.
REQ-016 req_ready is combinational from req_valid, pointer and state; zero in EVAL and RESP.
REQ-017 IDLE handshake at edge T: latch granted operands into registers driving add_a/add_b, latch grant id, go to EVAL.
REQ-018 EVAL: one cycle; at edge T+1 capture add_sum into resp_sum register, go to RESP.
REQ-019 RESP: resp_valid[grant]=1 from cycle after T+1 until resp_ready[grant] seen at an edge; the other resp_valid bit stays 0.
REQ-020 Response handshake: go to IDLE, set pointer to the other requester, increment ops_served.
REQ-021 Minimum latency: request handshake to resp_valid high = 2 cycles; minimum issue interval = 3 cycles.
REQ-022 add_a/add_b hold the latched operands stable from T until the next request handshake.
REQ-023 resp_sum holds its value after the response handshake until the next EVAL capture.
REQ-024 resp_ready on the non-granted bit is ignored; resp_ready in IDLE/EVAL is ignored.
REQ-025 req_valid dropped while in EVAL/RESP has no effect on the in-flight operation.
REQ-026 ops_served wraps from 16'hFFFF to 0.
REQ-027 Single continuously-valid requester with the other idle is served back-to-back regardless of pointer.

Reset
REQ-028 On rst: state IDLE, pointer=0, grant=0, add_a=add_b=0, resp_sum=0, ops_served=0.
REQ-029 During rst-high cycles req_ready=0, resp_valid=0, busy=0.
REQ-030 rst in EVAL or RESP aborts the operation; no response is issued and ops_served is not incremented.

Structure
REQ-031 Shared package holds the FSM state encoding (2-bit) and WIDTH default constant.
REQ-032 One sub-module, rr_arbiter2: 2-way round-robin grant from valid vector and pointer.
REQ-033 The adder itself is external; the block contains no arithmetic except the ops_served incrementer.

Verification
REQ-034 Single request: req_valid=01, a=5, b=9, resp_ready=1 -> resp_valid=01 2 cycles after accept, resp_sum=14, ops_served=1.
REQ-035 Simultaneous: both valid after reset (0: 3+4, 1: 100+200) -> requester 0 served first (7), then requester 1 (300); ops_served=2.
REQ-036 Fairness: both held valid 10 ops -> grants strictly alternate 0,1,0,1...
REQ-037 Backpressure: resp_ready low 5 cycles -> resp_valid and resp_sum (16383+16383=32766) held; req_ready stays 00.
REQ-038 Mid-op reset: rst during EVAL -> next cycle state IDLE, resp_valid=00, ops_served unchanged at 0.
REQ-039 Bench checks resp_sum against a+b for 1000 random operand pairs from both requesters with random resp_ready stalls.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and default operand width.
package adder_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on contention the pointer decides.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    // One-hot grant plus its index, zero when nobody is asking
    always_comb begin
        grant_o    = 2'b00;
        grant_id_o = 1'b0;
        case (valid_i)
            2'b01: begin
                grant_o    = 2'b01;
                grant_id_o = 1'b0;
            end
            2'b10: begin
                grant_o    = 2'b10;
                grant_id_o = 1'b1;
            end
            2'b11: begin
                grant_o    = ptr_i ? 2'b10 : 2'b01;
                grant_id_o = ptr_i;
            end
            default: begin
                grant_o    = 2'b00;
                grant_id_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external combinational adder between two requesters, one operation in flight.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH:0]   resp_sum,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_sum,
    output logic             busy,
    output logic [15:0]      ops_served
);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic [15:0]      ops_q, ops_d;

    logic [1:0]       arb_grant;
    logic             arb_id;
    logic             req_fire;

    rr_arbiter2 u_arb (
        .valid_i    (req_valid),
        .ptr_i      (ptr_q),
        .grant_o    (arb_grant),
        .grant_id_o (arb_id)
    );

    // Grants are only offered while idle; reset masks every handshake-facing output
    assign req_ready  = (state_q == ST_IDLE && !rst) ? arb_grant : 2'b00;
    assign req_fire   = |(req_valid & req_ready);
    assign busy       = (state_q != ST_IDLE) && !rst;
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign resp_sum   = sum_q;
    assign ops_served = ops_q;

    // Only the granted requester sees its response valid bit
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp_valid
            assign resp_valid[gi] = (state_q == ST_RESP) && !rst && (grant_q == 1'(gi));
        end
    endgenerate

    // Next-state logic: latch operands on accept, capture the sum after one cycle, retire on response accept
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ops_d   = ops_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    grant_d = arb_id;
                    a_d     = arb_id ? req1_a : req0_a;
                    b_d     = arb_id ? req1_b : req0_b;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                sum_d   = add_sum;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready[grant_q]) begin
                    ptr_d   = ~grant_q;
                    ops_d   = ops_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset mid-operation simply drops the request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ops_q   <= ops_d;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed table, hand-written corner sequences, random run.
module tb_adder_arbiter;

    localparam int W = 14;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W:0]     resp_sum;
    logic [W-1:0]   add_a, add_b;
    logic [W:0]     add_sum;
    logic           busy;
    logic [15:0]    ops_served;

    int tests = 0;
    int fails = 0;
    int exp_ops = 0;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .busy       (busy),
        .ops_served (ops_served)
    );

    // External shared adder
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   valid;
        logic [W-1:0] a0, b0, a1, b1;
        int           grant;
        logic [W:0]   sum;
        int           stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst     = 1'b0;
        exp_ops = 0;
        #1;
        chk("rst_ops", 32'(ops_served), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_sum", 32'(resp_sum), 32'd0);
    endtask

    // One full operation: accept, EVAL, RESP with optional stall, response handshake
    task automatic do_op(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int g, input logic [W:0] exp_sum, input int stall);
        logic [1:0]   oh;
        logic [W-1:0] ea, eb;
        oh = (g == 1) ? 2'b10 : 2'b01;
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        req_valid = v;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        resp_ready = 2'b00;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(oh));
        tick();
        req_valid = 2'b00;
        #1;
        chk("eval_busy", 32'(busy), 32'd1);
        chk("eval_req_ready", 32'(req_ready), 32'd0);
        chk("eval_resp_valid", 32'(resp_valid), 32'd0);
        chk("eval_add_a", 32'(add_a), 32'(ea));
        chk("eval_add_b", 32'(add_b), 32'(eb));
        tick();
        chk("resp_valid", 32'(resp_valid), 32'(oh));
        chk("resp_sum", 32'(resp_sum), 32'(exp_sum));
        for (int s = 0; s < stall; s++) begin
            resp_ready = ~oh;
            req_valid  = 2'b11;
            tick();
            chk("stall_resp_valid", 32'(resp_valid), 32'(oh));
            chk("stall_resp_sum", 32'(resp_sum), 32'(exp_sum));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid  = 2'b00;
        resp_ready = oh;
        tick();
        exp_ops++;
        resp_ready = 2'b00;
        #1;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_resp_valid", 32'(resp_valid), 32'd0);
        chk("done_ops", 32'(ops_served), 32'(exp_ops));
        chk("done_sum_hold", 32'(resp_sum), 32'(exp_sum));
        chk("done_add_a_hold", 32'(add_a), 32'(ea));
    endtask

    vec_t vecs[7];

    initial begin
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Pointer starts at 0 after reset; each entry's grant follows the previous one
        vecs[0] = '{2'b01, 14'd5,     14'd9,     14'd0,     14'd0,     0, 15'd14,    0};
        vecs[1] = '{2'b11, 14'd3,     14'd4,     14'd100,   14'd200,   1, 15'd300,   0};
        vecs[2] = '{2'b11, 14'd3,     14'd4,     14'd100,   14'd200,   0, 15'd7,     0};
        vecs[3] = '{2'b10, 14'd0,     14'd0,     14'd16383, 14'd16383, 1, 15'd32766, 5};
        vecs[4] = '{2'b10, 14'd0,     14'd0,     14'd1,     14'd2,     1, 15'd3,     0};
        vecs[5] = '{2'b01, 14'd0,     14'd0,     14'd7,     14'd7,     0, 15'd0,     0};
        vecs[6] = '{2'b01, 14'd16383, 14'd1,     14'd9,     14'd9,     0, 15'd16384, 2};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d valid=%b grant=%0d sum=%0d", i, vecs[i].valid, vecs[i].grant, vecs[i].sum);
            do_op(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                  vecs[i].grant, vecs[i].sum, vecs[i].stall);
        end

        // Simultaneous requests straight after reset: requester 0 first
        do_reset();
        do_op(2'b11, 14'd3, 14'd4, 14'd100, 14'd200, 0, 15'd7, 0);
        do_op(2'b11, 14'd3, 14'd4, 14'd100, 14'd200, 1, 15'd300, 0);
        chk("simul_ops", 32'(ops_served), 32'd2);
        $display("[TB] simultaneous pair done ops=%0d", ops_served);

        // Fairness: both always valid, grants must alternate
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] x0, y0, x1, y1;
            logic [W:0]   es;
            x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
            es = (i % 2 == 1) ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
            do_op(2'b11, x0, y0, x1, y1, i % 2, es, 0);
            $display("[TB] fairness op %0d expected grant %0d", i, i % 2);
        end

        // Reset during EVAL aborts the operation
        do_reset();
        req_valid = 2'b01; req0_a = 14'd11; req0_b = 14'd22;
        tick();
        chk("abort_eval_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rst_busy", 32'(busy), 32'd0);
        chk("abort_rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_ops", 32'(ops_served), 32'd0);
        tick(); tick();
        chk("abort_later_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_later_ops", 32'(ops_served), 32'd0);
        $display("[TB] mid-op reset in EVAL done");

        // Reset during RESP also drops the response
        do_reset();
        req_valid = 2'b10; req1_a = 14'd1; req1_b = 14'd1;
        tick(); req_valid = 2'b00;
        tick();
        chk("abort2_resp_valid", 32'(resp_valid), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0; resp_ready = 2'b11;
        tick();
        chk("abort2_resp_valid_after", 32'(resp_valid), 32'd0);
        chk("abort2_ops", 32'(ops_served), 32'd0);
        $display("[TB] mid-op reset in RESP done");

        // Random run against a transaction-level model
        do_reset();
        begin
            int         done_ops = 0;
            int         cyc = 0;
            bit         inflight = 0;
            int         age = 0;
            logic       m_id = 1'b0;
            logic       m_ptr = 1'b0;
            logic [W:0] m_sum = '0;
            while (done_ops < 1000 && cyc < 20000) begin
                logic [1:0] exp_rdy, exp_rv;
                bit         acc, fin;
                req_valid = 2'($urandom_range(0, 3));
                req0_a = W'($urandom); req0_b = W'($urandom);
                req1_a = W'($urandom); req1_b = W'($urandom);
                resp_ready[0] = ($urandom_range(0, 3) != 0);
                resp_ready[1] = ($urandom_range(0, 3) != 0);
                #1;
                if (inflight) exp_rdy = 2'b00;
                else if (req_valid == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
                else exp_rdy = req_valid;
                exp_rv = (inflight && age >= 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
                chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
                if (exp_rv != 2'b00) chk("rnd_resp_sum", 32'(resp_sum), 32'(m_sum));
                acc = (exp_rdy != 2'b00);
                fin = (exp_rv != 2'b00) && resp_ready[m_id];
                tick();
                if (fin) begin
                    $display("[TB] rnd op %0d id=%0d sum=%0d", done_ops, m_id, m_sum);
                    inflight = 0;
                    m_ptr    = ~m_id;
                    done_ops++;
                    exp_ops++;
                end
                if (acc) begin
                    inflight = 1;
                    age      = 0;
                    m_id     = (exp_rdy == 2'b10);
                    m_sum    = m_id ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
                end else if (inflight) begin
                    age++;
                end
                cyc++;
            end
            chk("rnd_ops_completed", 32'(done_ops), 32'd1000);
            chk("rnd_ops_served", 32'(ops_served), 32'(16'(exp_ops)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
